// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory port: FSM states,
// RV32I funct3 size codes and the access legality checks.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic mis;
    case (funct3)
      F3_H, F3_HU: mis = addr_lo[0];
      F3_W:        mis = (addr_lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Stores only know B/H/W; loads additionally allow the unsigned B/H forms.
  function automatic logic is_illegal(input logic       store,
                                      input logic [2:0] funct3);
    logic ill;
    if (store)
      ill = (funct3 > F3_W);
    else
      ill = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    return ill;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: extracts and extends load data from a memory word and
// merges sub-word store data into a memory word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;
  logic [4:0]         b_base;
  logic [4:0]         h_base;

  assign b_base = {addr_lo, 3'b000};
  assign h_base = {addr_lo[1], 4'b0000};

  always_comb begin
    lane_b = word[b_base +: 8];
    lane_h = word[h_base +: 16];
    case (funct3)
      F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
      F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
      F3_BU:   load_data = {24'h000000, lane_b};
      F3_HU:   load_data = {16'h0000, lane_h};
      default: load_data = word;
    endcase
  end

  // Untouched lanes keep the word just read, so the write is always a full word.
  always_comb begin
    store_data = word;
    case (funct3)
      F3_B:    store_data[b_base +: 8]  = wdata[7:0];
      F3_H:    store_data[h_base +: 16] = wdata[15:0];
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Single-outstanding RV32I load/store initiator; sub-word stores are done as
// read-modify-write so the memory only ever receives full 32-bit words.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t        state;
  logic              store_q;
  logic [2:0]        funct3_q;
  logic [1:0]        addr_lo_q;
  logic [31:0]       wdata_q;
  logic [31:0]       buf_q;

  logic              req_err;
  logic [ADDR_W-1:0] req_word_addr;
  logic [31:0]       align_word;
  logic [31:0]       load_data;
  logic [31:0]       store_data;

  assign req_err       = is_misaligned(req_funct3, req_addr[1:0]) ||
                         is_illegal(req_store, req_funct3);
  assign req_word_addr = {req_addr[ADDR_W-1:2], 2'b00};

  // During RD the word arrives combinationally; the lane logic works on it
  // directly so the response/merge is ready at the same edge that buffers it.
  assign align_word = (state == S_RD) ? mem_rdata : buf_q;

  lsu_lane_align u_align (
    .word       (align_word),
    .wdata      (wdata_q),
    .funct3     (funct3_q),
    .addr_lo    (addr_lo_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'h0;
      store_q    <= 1'b0;
      funct3_q   <= 3'b000;
      addr_lo_q  <= 2'b00;
      wdata_q    <= 32'h0;
      buf_q      <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            store_q   <= req_store;
            funct3_q  <= req_funct3;
            addr_lo_q <= req_addr[1:0];
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (req_err) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else if (req_store && req_funct3 == F3_W) begin
              state     <= S_WR;
              mem_wr    <= 1'b1;
              mem_addr  <= req_word_addr;
              mem_wdata <= req_wdata;
            end else begin
              state    <= S_RD;
              mem_rd   <= 1'b1;
              mem_addr <= req_word_addr;
            end
          end
        end

        S_RD: begin
          mem_rd <= 1'b0;
          buf_q  <= mem_rdata;
          if (store_q) begin
            state     <= S_WR;
            mem_wr    <= 1'b1;
            mem_wdata <= store_data;
          end else begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= load_data;
          end
        end

        S_WR: begin
          mem_wr     <= 1'b0;
          state      <= S_RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
        end

        S_RESP: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            req_ready  <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: directed scenarios plus random traffic, checked
// against a byte-array reference memory with arithmetic load extension.
module tb_lsu_mem_port;

  localparam int ADDR_W = 12;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [31:0]       mem_rdata;

  logic [31:0] mem [1024];
  logic [7:0]  ref_b [4096];

  int n_cmp = 0;
  int n_err = 0;

  lsu_mem_port #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem_rd ? mem[mem_addr[11:2]] : 32'h0;

  always @(posedge clk)
    if (mem_wr) mem[mem_addr[11:2]] <= mem_wdata;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic exp_error(input logic st, input logic [2:0] f3,
                                     input logic [11:0] a);
    int f = int'(f3);
    if (st && f > 2) return 1'b1;
    if (!st && (f == 3 || f == 6 || f == 7)) return 1'b1;
    return (int'(a) % acc_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] ref_word(input logic [11:0] a);
    int base = int'(a) - int'(a) % 4;
    int v = 0;
    for (int i = 0; i < 4; i++) v += int'(ref_b[base + i]) << (8 * i);
    return v;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3,
                                           input logic [11:0] a);
    int ai = int'(a);
    int v;
    case (f3)
      3'b000: begin v = int'(ref_b[ai]); if (v > 127) v -= 256; end
      3'b100: v = int'(ref_b[ai]);
      3'b001: begin
        v = int'(ref_b[ai]) + 256 * int'(ref_b[ai + 1]);
        if (v > 32767) v -= 65536;
      end
      3'b101: v = int'(ref_b[ai]) + 256 * int'(ref_b[ai + 1]);
      default: v = ref_word(a);
    endcase
    return v;
  endfunction

  task automatic set_word(input logic [11:0] a, input logic [31:0] w);
    int base = int'(a) - int'(a) % 4;
    mem[base / 4] <= w;
    for (int i = 0; i < 4; i++) ref_b[base + i] = w[8*i +: 8];
  endtask

  // ---------------- one transaction ----------------
  task automatic do_req(input logic st, input logic [2:0] f3,
                        input logic [11:0] a, input logic [31:0] wd,
                        input int hold, output logic [31:0] rd_out,
                        output logic err_out);
    logic        e_err;
    logic [31:0] e_val;
    logic [31:0] e_wword;
    int          e_lat, e_nrd, e_nwr;
    int          cyc, nrd, nwr, both;
    logic [31:0] wword, seen_rdata;
    logic        seen_err;

    e_err   = exp_error(st, f3, a);
    e_val   = 32'h0;
    e_wword = 32'h0;
    if (e_err) begin
      e_lat = 1; e_nrd = 0; e_nwr = 0;
    end else if (!st) begin
      e_lat = 2; e_nrd = 1; e_nwr = 0;
      e_val = exp_load(f3, a);
    end else begin
      for (int i = 0; i < acc_size(f3); i++) ref_b[int'(a) + i] = wd[8*i +: 8];
      e_wword = ref_word(a);
      e_nwr = 1;
      if (acc_size(f3) == 4) begin e_lat = 2; e_nrd = 0; end
      else begin e_lat = 3; e_nrd = 1; end
    end

    @(negedge clk);
    check_eq("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_store  = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = 12'($urandom);
    req_wdata  = $urandom;

    cyc = 1; nrd = 0; nwr = 0; both = 0; wword = 32'h0;
    while (!resp_valid && cyc < 10) begin
      if (mem_rd) begin
        nrd++;
        check_eq("rd_addr", 32'(mem_addr), 32'(int'(a) - int'(a) % 4));
      end
      if (mem_wr) begin
        nwr++;
        wword = mem_wdata;
        check_eq("wr_addr", 32'(mem_addr), 32'(int'(a) - int'(a) % 4));
      end
      if (mem_rd && mem_wr) both = 1;
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("latency", 32'(cyc), 32'(e_lat));
    check_eq("resp_valid", 32'(resp_valid), 32'd1);
    rd_out  = resp_rdata;
    err_out = resp_err;
    if (!resp_valid) return;

    check_eq("rd_pulses", 32'(nrd), 32'(e_nrd));
    check_eq("wr_pulses", 32'(nwr), 32'(e_nwr));
    check_eq("strobe_overlap", 32'(both), 32'd0);
    check_eq("resp_err", 32'(resp_err), 32'(e_err));
    check_eq("resp_rdata", resp_rdata, e_val);
    if (st && !e_err) check_eq("wr_data", wword, e_wword);

    seen_rdata = resp_rdata;
    seen_err   = resp_err;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      check_eq("hold_valid", 32'(resp_valid), 32'd1);
      check_eq("hold_rdata", resp_rdata, seen_rdata);
      check_eq("hold_err", 32'(resp_err), 32'(seen_err));
      check_eq("hold_busy", 32'(req_ready), 32'd0);
      check_eq("hold_strobes", 32'({mem_rd, mem_wr}), 32'd0);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check_eq("post_valid", 32'(resp_valid), 32'd0);
    check_eq("post_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    logic [11:0] a;
    logic [2:0]  f3;
    logic        st;
    int          sz;

    rst_n      = 1'b1;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = 32'h0;
    resp_ready = 1'b0;
    for (int i = 0; i < 1024; i++) set_word(12'(i * 4), $urandom);

    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_resp_err", 32'(resp_err), 32'd0);
    check_eq("rst_resp_rdata", resp_rdata, 32'h0);
    check_eq("rst_strobes", 32'({mem_rd, mem_wr}), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // directed loads
    set_word(12'h010, 32'h8899AABB);
    do_req(1'b0, 3'b010, 12'h010, 32'h0, 0, r, e);
    check_eq("lw_plan", r, 32'h8899AABB);
    set_word(12'h020, 32'h00000080);
    do_req(1'b0, 3'b000, 12'h020, 32'h0, 1, r, e);
    check_eq("lb_plan", r, 32'hFFFFFF80);
    do_req(1'b0, 3'b100, 12'h020, 32'h0, 0, r, e);
    check_eq("lbu_plan", r, 32'h00000080);
    set_word(12'h020, 32'h80010000);
    do_req(1'b0, 3'b001, 12'h022, 32'h0, 0, r, e);
    check_eq("lh_plan", r, 32'hFFFF8001);

    // read-modify-write byte store
    set_word(12'h030, 32'hDEADBEEF);
    do_req(1'b1, 3'b000, 12'h031, 32'h12345678, 0, r, e);
    check_eq("sb_plan_rdata", r, 32'h0);
    do_req(1'b0, 3'b010, 12'h030, 32'h0, 0, r, e);
    check_eq("sb_plan_readback", r, 32'hDEAD78EF);

    // error cases
    do_req(1'b0, 3'b010, 12'h013, 32'h0, 0, r, e);
    check_eq("lw_mis_err", 32'(e), 32'd1);
    do_req(1'b1, 3'b001, 12'h041, 32'hCAFEF00D, 0, r, e);
    check_eq("sh_mis_err", 32'(e), 32'd1);
    do_req(1'b0, 3'b011, 12'h040, 32'h0, 0, r, e);
    check_eq("f3_011_err", 32'(e), 32'd1);
    check_eq("f3_011_rdata", r, 32'h0);

    // long backpressure, then immediate follow-up
    do_req(1'b0, 3'b010, 12'h010, 32'h0, 5, r, e);
    check_eq("lw_hold", r, 32'h8899AABB);
    do_req(1'b0, 3'b101, 12'h012, 32'h0, 0, r, e);
    check_eq("lhu_after_hold", r, 32'h00008899);

    // reset during the read phase of a halfword store
    set_word(12'h040, 32'h01234567);
    @(negedge clk);
    req_valid  = 1'b1;
    req_store  = 1'b1;
    req_funct3 = 3'b001;
    req_addr   = 12'h042;
    req_wdata  = 32'hFFFFAAAA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_eq("mid_rd_high", 32'(mem_rd), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rd_dropped", 32'(mem_rd), 32'd0);
    check_eq("mid_ready", 32'(req_ready), 32'd1);
    check_eq("mid_resp_valid", 32'(resp_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check_eq("mid_no_wr", 32'(mem_wr), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mid_mem_kept", mem[12'h040 >> 2], 32'h01234567);
    check_eq("mid_ready_after", 32'(req_ready), 32'd1);

    // random traffic over a small window so stores and loads collide
    for (int n = 0; n < 150; n++) begin
      st = 1'($urandom);
      f3 = 3'($urandom_range(0, 7));
      a  = 12'($urandom_range(0, 255));
      sz = acc_size(f3);
      if ($urandom_range(0, 3) != 0) a = 12'(int'(a) - int'(a) % sz);
      do_req(st, f3, a, $urandom, $urandom_range(0, 3), r, e);
    end

    for (int w = 0; w < 64; w++)
      check_eq("final_mem", mem[w], ref_word(12'(w * 4)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
